// File: rtl/led_pattern_seq.sv
// rtl/led_pattern_seq.sv - tick-driven LED pattern sequencer (blink, rotate, bounce, binary count)
//
// Ports:
//   clk   - system clock, shared with the upstream 1 Hz divider
//   rst   - synchronous reset, active-high
//   tick  - single-cycle step enable from the divider
//   mode  - pattern select: 0 BLINK, 1 SHIFT, 2 BOUNCE, 3 COUNT
//   pause - holds the pattern; ticks are ignored while high
//   leds  - registered LED drive, WIDTH bits
//   wrap  - registered one-cycle pulse on completion of a pattern period
module led_pattern_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [1:0]       mode,
    input  logic             pause,
    output logic [WIDTH-1:0] leds,
    output logic             wrap
);

    typedef enum logic [1:0] {
        BLINK  = 2'd0,
        SHIFT  = 2'd1,
        BOUNCE = 2'd2,
        COUNT  = 2'd3
    } mode_e;

    localparam logic             DIR_LEFT  = 1'b0;
    localparam logic             DIR_RIGHT = 1'b1;
    localparam logic [WIDTH-1:0] LSB_HOT   = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_HOT   = LSB_HOT << (WIDTH - 1);

    mode_e            mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] leds_q, leds_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] rotated;
    logic             is_one_hot;

    assign rotated    = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
    assign is_one_hot = (leds_q != '0) && ((leds_q & (leds_q - LSB_HOT)) == '0);

    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        leds_d = leds_q;
        wrap_d = 1'b0;

        if (mode_e'(mode) != mode_q) begin
            // Mode change wins over a coincident tick, which is dropped.
            mode_d = mode_e'(mode);
            dir_d  = DIR_LEFT;
            case (mode_e'(mode))
                SHIFT, BOUNCE: leds_d = LSB_HOT;
                default:       leds_d = '0;
            endcase
        end else if (tick && !pause) begin
            case (mode_q)
                BLINK: begin
                    leds_d = ~leds_q;
                    wrap_d = (~leds_q == '0);
                end
                SHIFT: begin
                    leds_d = rotated;
                    wrap_d = leds_q[WIDTH-1];
                end
                BOUNCE: begin
                    if (!is_one_hot) begin
                        // Not reachable from a start value; behave as SHIFT.
                        leds_d = rotated;
                        wrap_d = leds_q[WIDTH-1];
                    end else if (dir_q == DIR_LEFT) begin
                        leds_d = leds_q << 1;
                        if ((leds_q << 1) == MSB_HOT) dir_d = DIR_RIGHT;
                    end else begin
                        leds_d = leds_q >> 1;
                        if ((leds_q >> 1) == LSB_HOT) begin
                            dir_d  = DIR_LEFT;
                            wrap_d = 1'b1;
                        end
                    end
                end
                default: begin
                    leds_d = leds_q + LSB_HOT;
                    wrap_d = (leds_q == '1);
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= BLINK;
            dir_q  <= DIR_LEFT;
            leds_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
            leds_q <= leds_d;
            wrap_q <= wrap_d;
        end
    end

    assign leds = leds_q;
    assign wrap = wrap_q;

endmodule
